// File: rtl/draw_board_background.sv
// Pixel-pipeline stage painting the Memory Game playfield: edge lines, background, board,
// face-down tile grid and a blinking cursor outline. Timing passes through with 2-cycle latency.
module draw_board_background #(
  parameter int unsigned H_ACTIVE     = 1024,
  parameter int unsigned V_ACTIVE     = 768,
  parameter int unsigned GRID_COLS    = 4,
  parameter int unsigned GRID_ROWS    = 4,
  parameter int unsigned TILE_W       = 160,
  parameter int unsigned TILE_H       = 120,
  parameter int unsigned GAP          = 32,
  parameter int unsigned X0           = 144,
  parameter int unsigned Y0           = 96,
  parameter int unsigned OUTLINE      = 4,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] C_BG         = 12'h888,
  parameter logic [11:0] C_BOARD      = 12'h555,
  parameter logic [11:0] C_TILE       = 12'h248,
  parameter logic [11:0] C_CURSOR     = 12'hfff
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [10:0] vcount_in,
  input  logic [10:0] hcount_in,
  input  logic        vsync_in,
  input  logic        hsync_in,
  input  logic        vblnk_in,
  input  logic        hblnk_in,
  input  logic [2:0]  cursor_col,
  input  logic [2:0]  cursor_row,
  input  logic        blink_en,
  output logic [10:0] vcount_out,
  output logic [10:0] hcount_out,
  output logic        vsync_out,
  output logic        hsync_out,
  output logic        vblnk_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam int unsigned PITCH_X = TILE_W + GAP;
  localparam int unsigned PITCH_Y = TILE_H + GAP;

  localparam logic [10:0] X0_C     = 11'(X0);
  localparam logic [10:0] Y0_C     = 11'(Y0);
  localparam logic [10:0] XEND_C   = 11'(X0 + GRID_COLS * PITCH_X - GAP);
  localparam logic [10:0] YEND_C   = 11'(Y0 + GRID_ROWS * PITCH_Y - GAP);
  localparam logic [10:0] PXM1_C   = 11'(PITCH_X - 1);
  localparam logic [10:0] PYM1_C   = 11'(PITCH_Y - 1);
  localparam logic [10:0] TW_C     = 11'(TILE_W);
  localparam logic [10:0] TH_C     = 11'(TILE_H);
  localparam logic [10:0] OL_C     = 11'(OUTLINE);
  localparam logic [10:0] TW_OL_C  = 11'(TILE_W - OUTLINE);
  localparam logic [10:0] TH_OL_C  = 11'(TILE_H - OUTLINE);
  localparam logic [10:0] HLAST_C  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] VLAST_C  = 11'(V_ACTIVE - 1);
  localparam logic [3:0]  GC_C     = 4'(GRID_COLS);
  localparam logic [3:0]  GR_C     = 4'(GRID_ROWS);
  localparam logic [15:0] BFM1_C   = 16'(BLINK_FRAMES - 1);

  // Stage 1 state
  logic [10:0] vcount_q, vcount_d, hcount_q, hcount_d;
  logic        vsync_q, vsync_d, hsync_q, hsync_d, vblnk_q, vblnk_d, hblnk_q, hblnk_d;
  logic [10:0] x_off_q, x_off_d, y_off_q, y_off_d;
  logic [2:0]  col_q, col_d, row_q, row_d;
  logic        in_x_q, in_x_d, in_y_q, in_y_d;
  // Frame-rate control state
  logic        vsync_prev_q, vsync_prev_d;
  logic [2:0]  cur_col_q, cur_col_d, cur_row_q, cur_row_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  // Stage 2 state
  logic [10:0] vcount_o_q, vcount_o_d, hcount_o_q, hcount_o_d;
  logic        vsync_o_q, vsync_o_d, hsync_o_q, hsync_o_d, vblnk_o_q, vblnk_o_d;
  logic        hblnk_o_q, hblnk_o_d;
  logic [11:0] rgb_q, rgb_d;

  logic vsync_rise, in_tile, on_edge, is_cursor;

  always_comb begin
    vcount_d = vcount_in;
    hcount_d = hcount_in;
    vsync_d  = vsync_in;
    hsync_d  = hsync_in;
    vblnk_d  = vblnk_in;
    hblnk_d  = hblnk_in;
    x_off_d  = x_off_q;
    col_d    = col_q;
    y_off_d  = y_off_q;
    row_d    = row_q;
    in_x_d   = (hcount_in >= X0_C) && (hcount_in < XEND_C);
    in_y_d   = (vcount_in >= Y0_C) && (vcount_in < YEND_C);

    // Running tile counters; they assume hcount_in advances by one per pixel clock.
    if (hcount_in == X0_C) begin
      x_off_d = '0;
      col_d   = '0;
    end else if (in_x_d) begin
      if (x_off_q == PXM1_C) begin
        x_off_d = '0;
        col_d   = col_q + 3'd1;
      end else begin
        x_off_d = x_off_q + 11'd1;
      end
    end

    if (hcount_in == 11'd0) begin
      if (vcount_in == Y0_C) begin
        y_off_d = '0;
        row_d   = '0;
      end else if (in_y_d) begin
        if (y_off_q == PYM1_C) begin
          y_off_d = '0;
          row_d   = row_q + 3'd1;
        end else begin
          y_off_d = y_off_q + 11'd1;
        end
      end
    end
  end

  always_comb begin
    vsync_prev_d  = vsync_in;
    vsync_rise    = vsync_in && !vsync_prev_q;
    cur_col_d     = cur_col_q;
    cur_row_d     = cur_row_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;

    if (vsync_rise) begin
      cur_col_d = cursor_col;
      cur_row_d = cursor_row;
    end

    // A disabled blink overrides a coincident wrap.
    if (!blink_en) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (vsync_rise) begin
      if (frame_cnt_q >= BFM1_C) begin
        frame_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    vcount_o_d = vcount_q;
    hcount_o_d = hcount_q;
    vsync_o_d  = vsync_q;
    hsync_o_d  = hsync_q;
    vblnk_o_d  = vblnk_q;
    hblnk_o_d  = hblnk_q;

    in_tile   = in_x_q && in_y_q && (x_off_q < TW_C) && (y_off_q < TH_C);
    on_edge   = (x_off_q < OL_C) || (x_off_q >= TW_OL_C) ||
                (y_off_q < OL_C) || (y_off_q >= TH_OL_C);
    is_cursor = (col_q == cur_col_q) && (row_q == cur_row_q) &&
                ({1'b0, cur_col_q} < GC_C) && ({1'b0, cur_row_q} < GR_C);

    if (vblnk_q || hblnk_q)                       rgb_d = 12'h000;
    else if (vcount_q == 11'd0)                   rgb_d = 12'hff0;
    else if (vcount_q == VLAST_C)                 rgb_d = 12'hf00;
    else if (hcount_q == 11'd0)                   rgb_d = 12'h0f0;
    else if (hcount_q == HLAST_C)                 rgb_d = 12'h00f;
    else if (in_tile && is_cursor && on_edge && blink_phase_q) rgb_d = C_CURSOR;
    else if (in_tile)                             rgb_d = C_TILE;
    else if (in_x_q && in_y_q)                    rgb_d = C_BOARD;
    else                                          rgb_d = C_BG;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vcount_q      <= '0;
      hcount_q      <= '0;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      x_off_q       <= '0;
      y_off_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      in_x_q        <= 1'b0;
      in_y_q        <= 1'b0;
      vsync_prev_q  <= 1'b0;
      cur_col_q     <= '0;
      cur_row_q     <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      vcount_o_q    <= '0;
      hcount_o_q    <= '0;
      vsync_o_q     <= 1'b0;
      hsync_o_q     <= 1'b0;
      vblnk_o_q     <= 1'b0;
      hblnk_o_q     <= 1'b0;
      rgb_q         <= '0;
    end else begin
      vcount_q      <= vcount_d;
      hcount_q      <= hcount_d;
      vsync_q       <= vsync_d;
      hsync_q       <= hsync_d;
      vblnk_q       <= vblnk_d;
      hblnk_q       <= hblnk_d;
      x_off_q       <= x_off_d;
      y_off_q       <= y_off_d;
      col_q         <= col_d;
      row_q         <= row_d;
      in_x_q        <= in_x_d;
      in_y_q        <= in_y_d;
      vsync_prev_q  <= vsync_prev_d;
      cur_col_q     <= cur_col_d;
      cur_row_q     <= cur_row_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      vcount_o_q    <= vcount_o_d;
      hcount_o_q    <= hcount_o_d;
      vsync_o_q     <= vsync_o_d;
      hsync_o_q     <= hsync_o_d;
      vblnk_o_q     <= vblnk_o_d;
      hblnk_o_q     <= hblnk_o_d;
      rgb_q         <= rgb_d;
    end
  end

  assign vcount_out = vcount_o_q;
  assign hcount_out = hcount_o_q;
  assign vsync_out  = vsync_o_q;
  assign hsync_out  = hsync_o_q;
  assign vblnk_out  = vblnk_o_q;
  assign hblnk_out  = hblnk_o_q;
  assign rgb_out    = rgb_q;

endmodule
